// File: rtl/bstr_tx_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bstr_tx_arb : fixed-priority (hs > tok > data) transmit bitstream scheduler
//   serialises one packet, then appends EOP (SE0,SE0,J) and an idle gap.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bstr_tx_arb #(
   parameter int TOK_LEN  = 32,
   parameter int DATA_LEN = 96,
   parameter int HS_LEN   = 16,
   parameter int IFG      = 2
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       tok_req,
   input  logic       data_req,
   input  logic       hs_req,
   input  logic       tok_bit,
   input  logic       data_bit,
   input  logic       hs_bit,
   output logic [2:0] gnt,
   output logic       bstr_out,
   output logic [1:0] bstr_out_ready,
   output logic       eop,
   output logic       busy,
   output logic       done,
   output logic       abort
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_EOP  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam logic [6:0] TOK_LAST  = 7'(TOK_LEN - 1);
   localparam logic [6:0] DATA_LAST = 7'(DATA_LEN - 1);
   localparam logic [6:0] HS_LAST   = 7'(HS_LEN - 1);
   localparam logic [6:0] IFG_LAST  = 7'((IFG > 0) ? (IFG - 1) : 0);

   state_t     state;
   logic [6:0] cnt;
   logic [6:0] len_last;
   logic [1:0] pkt_type;
   logic       aborted;

   logic req_live;
   logic bit_mux;

   assign req_live = |(gnt & {hs_req, data_req, tok_req});
   assign bit_mux  = |(gnt & {hs_bit, data_bit, tok_bit});

   // A granted source dropping its request turns the current bit into idle J.
   always_comb begin
      bstr_out       = 1'b1;
      bstr_out_ready = 2'b00;
      case (state)
         S_SEND: begin
            if (req_live) begin
               bstr_out       = bit_mux;
               bstr_out_ready = pkt_type;
            end
         end
         S_EOP:   bstr_out = (cnt == 7'd2);
         default: bstr_out = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state    <= S_IDLE;
         cnt      <= 7'd0;
         len_last <= 7'd0;
         pkt_type <= 2'b00;
         aborted  <= 1'b0;
         gnt      <= 3'b000;
         eop      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         abort    <= 1'b0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt     <= 7'd0;
               aborted <= 1'b0;
               if (hs_req || tok_req || data_req) begin
                  state <= S_SEND;
                  busy  <= 1'b1;
                  if (hs_req) begin
                     gnt      <= 3'b100;
                     pkt_type <= 2'b11;
                     len_last <= HS_LAST;
                  end else if (tok_req) begin
                     gnt      <= 3'b001;
                     pkt_type <= 2'b01;
                     len_last <= TOK_LAST;
                  end else begin
                     gnt      <= 3'b010;
                     pkt_type <= 2'b10;
                     len_last <= DATA_LAST;
                  end
               end
            end
            S_SEND: begin
               if (!req_live || (cnt == len_last)) begin
                  state   <= S_EOP;
                  cnt     <= 7'd0;
                  gnt     <= 3'b000;
                  eop     <= 1'b1;
                  aborted <= !req_live;
                  abort   <= !req_live;
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end
            S_EOP: begin
               if (cnt == 7'd2) begin
                  eop <= 1'b0;
                  cnt <= 7'd0;
                  if (IFG == 0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  cnt <= cnt + 7'd1;
                  if ((cnt == 7'd1) && !aborted) done <= 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == IFG_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  cnt   <= 7'd0;
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bstr_tx_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bstr_tx_arb : scoreboard bench for bstr_tx_arb, random packet rounds.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bstr_tx_arb;

   localparam int IFG_P = 2;
   localparam int LENS [3] = '{32, 96, 16};   // index 0 tok, 1 data, 2 hs
   localparam int ORD  [3] = '{2, 0, 1};      // service order when all request

   typedef struct {
      int           src;
      int           start;
      int           sc;
      int           ab;
      logic [127:0] bits;
   } exp_t;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   logic [2:0] req_v = 3'b000;
   logic [2:0] bit_v = 3'b000;
   logic tok_req, data_req, hs_req, tok_bit, data_bit, hs_bit;
   logic [2:0] gnt;
   logic       bstr_out, eop, busy, done, abort;
   logic [1:0] bstr_out_ready;
   logic [2:0] z_gnt;
   logic       z_out, z_eop, z_busy, z_done, z_abort;
   logic [1:0] z_rdy;

   assign tok_req  = req_v[0];
   assign data_req = req_v[1];
   assign hs_req   = req_v[2];
   assign tok_bit  = bit_v[0];
   assign data_bit = bit_v[1];
   assign hs_bit   = bit_v[2];

   bstr_tx_arb #(.IFG(IFG_P)) dut (
      .clk(clk), .rst_b(rst_b),
      .tok_req(tok_req), .data_req(data_req), .hs_req(hs_req),
      .tok_bit(tok_bit), .data_bit(data_bit), .hs_bit(hs_bit),
      .gnt(gnt), .bstr_out(bstr_out), .bstr_out_ready(bstr_out_ready),
      .eop(eop), .busy(busy), .done(done), .abort(abort)
   );

   bstr_tx_arb #(.IFG(0)) dut_ifg0 (
      .clk(clk), .rst_b(rst_b),
      .tok_req(1'b1), .data_req(1'b0), .hs_req(1'b0),
      .tok_bit(1'b0), .data_bit(1'b0), .hs_bit(1'b0),
      .gnt(z_gnt), .bstr_out(z_out), .bstr_out_ready(z_rdy),
      .eop(z_eop), .busy(z_busy), .done(z_done), .abort(z_abort)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];
   bit mon_en = 1'b0;
   bit mon_busy = 1'b0;

   // source bookkeeping: main owns go/pkt/ab, the source process owns served/sent
   int           go     [3] = '{0, 0, 0};
   int           served [3] = '{0, 0, 0};
   int           sent   [3] = '{0, 0, 0};
   int           ab     [3] = '{-1, -1, -1};
   logic [127:0] pkt    [3];
   int           st_ab  [3];
   logic [127:0] st_bits[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [9:0] outv();
      return {gnt, bstr_out_ready, bstr_out, eop, busy, done, abort};
   endfunction

   localparam logic [9:0] IDLE_V = {3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   // Source model: drives bits while granted, drops req at the abort index or packet end.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (rst_b) begin
               sent[i] = 0;
            end else if (gnt[i]) begin
               if (ab[i] >= 0 && sent[i] == ab[i]) served[i] = go[i];
               bit_v[i] = pkt[i][sent[i]];
               sent[i]++;
            end else if (sent[i] > 0) begin
               served[i] = go[i];
               sent[i]   = 0;
            end
            req_v[i] = (go[i] != served[i]);
         end
      end
   end

   // Monitor: on each grant pop one expected packet and walk its SEND/EOP/GAP/IDLE cycles.
   initial begin
      exp_t r;
      logic [9:0] e;
      @(negedge clk);
      forever begin
         if (mon_en && !rst_b && gnt != 3'b000) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", {29'd0, gnt}, 32'd0);
            end else begin
               mon_busy = 1'b1;
               r = exp_q.pop_front();
               chk("start_cycle", cyc, r.start);
               for (int i = 0; i < r.sc; i++) begin
                  if (r.ab == i) e = {3'(1 << r.src), 2'b00, 1'b1, 4'b0100};
                  else           e = {3'(1 << r.src), 2'(r.src + 1), r.bits[i], 4'b0100};
                  chk("send", {22'd0, outv()}, {22'd0, e});
                  @(negedge clk);
               end
               for (int k = 0; k < 3; k++) begin
                  e = {5'b00000, (k == 2), 1'b1, 1'b1, (k == 2 && r.ab < 0), (k == 0 && r.ab >= 0)};
                  chk("eop", {22'd0, outv()}, {22'd0, e});
                  @(negedge clk);
               end
               for (int g = 0; g < IFG_P; g++) begin
                  chk("gap", {22'd0, outv()}, {22'd0, IDLE_V | 10'b0000000100});
                  @(negedge clk);
               end
               chk("idle", {22'd0, outv()}, {22'd0, IDLE_V});
               mon_busy = 1'b0;
            end
         end
         @(negedge clk);
      end
   end

   // IFG=0 instance with tok_req tied high: one grant every 32+3+1 cycles.
   initial begin
      int last = -1;
      int n = 0;
      bit prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_b) begin
            last = -1;
         end else if (z_gnt[0] && !prev) begin
            if (last >= 0 && n < 6) begin
               chk("ifg0_period", cyc - last, 36);
               n++;
            end
            last = cyc;
         end
         prev = z_gnt[0];
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || req_v != 3'b000 || mon_busy || exp_q.size() != 0) && n < 2000);
      if (n >= 2000) chk("idle_timeout", n, 0);
   endtask

   task automatic issue(input logic [2:0] sel);
      int t;
      exp_t r;
      t = cyc + 2;
      for (int k = 0; k < 3; k++) begin
         int p;
         p = ORD[k];
         if (sel[p]) begin
            pkt[p] = st_bits[p];
            ab[p]  = st_ab[p];
            go[p]++;
            r.src   = p;
            r.start = t;
            r.ab    = st_ab[p];
            r.bits  = st_bits[p];
            r.sc    = (st_ab[p] >= 0) ? st_ab[p] + 1 : LENS[p];
            exp_q.push_back(r);
            t += r.sc + 3 + IFG_P + 1;
         end
      end
   endtask

   task automatic randomize_src(input int p, input bit allow_abort);
      st_bits[p] = {$urandom, $urandom, $urandom, $urandom};
      st_ab[p]   = (allow_abort && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, LENS[p] - 1)) : -1;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {22'd0, outv()}, {22'd0, IDLE_V});
      rst_b = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // single token
      randomize_src(0, 1'b0);
      issue(3'b001);
      wait_idle();
      // all three at once: hs, then tok, then data
      for (int p = 0; p < 3; p++) randomize_src(p, 1'b0);
      issue(3'b111);
      wait_idle();
      // alternating data, aborted at SEND cycle 40, then complete
      st_bits[1] = {4{32'hAAAA_AAAA}};
      st_ab[1]   = 40;
      issue(3'b010);
      wait_idle();
      st_ab[1] = -1;
      issue(3'b010);
      wait_idle();

      // reset in the middle of a token packet
      mon_en = 1'b0;
      randomize_src(0, 1'b0);
      issue(3'b001);
      void'(exp_q.pop_back());
      n = 0;
      while (!gnt[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("grant_timeout", n, 0);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 rst_b = 1'b1;
      #1 chk("async_reset", {22'd0, outv()}, {22'd0, IDLE_V});
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      begin
         exp_t r;
         r.src = 0; r.start = cyc + 1; r.ab = -1; r.sc = LENS[0]; r.bits = pkt[0];
         exp_q.push_back(r);
      end
      mon_en = 1'b1;
      wait_idle();

      // randomized rounds
      for (int rnd = 0; rnd < 30; rnd++) begin
         logic [2:0] sel;
         sel = 3'($urandom_range(1, 7));
         for (int p = 0; p < 3; p++) randomize_src(p, 1'b1);
         issue(sel);
         wait_idle();
      end

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
